// File: rtl/tile_map_writer.sv
// Playfield tile map owner: loads a 20x15 level from a synchronous ROM, then serves
// handshaked tile writes and exposes the map flat plus a combinational render read port.
module tile_map_writer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start_i,
    input  logic [1:0]   level_sel_i,
    output logic [10:0]  rom_addr_o,
    input  logic [1:0]   rom_data_i,
    output logic         busy_o,
    output logic         load_done_o,
    input  logic         wr_req_i,
    input  logic [4:0]   wr_x_i,
    input  logic [3:0]   wr_y_i,
    input  logic [1:0]   wr_code_i,
    output logic         wr_ack_o,
    output logic         wr_err_o,
    input  logic [4:0]   rd_x_i,
    input  logic [3:0]   rd_y_i,
    output logic [1:0]   rd_code_o,
    output logic [599:0] map_flat_o
);

    localparam int unsigned MAP_W  = 20;
    localparam int unsigned MAP_H  = 15;
    localparam int unsigned TILES  = MAP_W * MAP_H;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned ROM_AW = 11;
    localparam int unsigned IDX_W  = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CODE_W-1:0] CODE_BORDER = 2'd3;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(TILES - 1);

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [ROM_AW-1:0]       rom_addr_q, rom_addr_d;
    logic                    fill_vld_q, fill_vld_d;
    logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;
    logic [CODE_W*TILES-1:0] map_q, map_d;
    logic                    busy_q, busy_d;
    logic                    load_done_q, load_done_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    wr_err_q, wr_err_d;

    logic              wr_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [CODE_W-1:0] wr_cur;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [ROM_AW-1:0] level_base;

    // Tile index y*20+x; out-of-range coordinates are steered to tile 0 and masked
    always_comb begin
        wr_in_range = (wr_x_i < 5'(MAP_W)) && (wr_y_i < 4'(MAP_H));
        wr_idx      = wr_in_range
                    ? (IDX_W'(wr_y_i) << 4) + (IDX_W'(wr_y_i) << 2) + IDX_W'(wr_x_i)
                    : '0;
        wr_cur      = map_q[{wr_idx, 1'b0} +: CODE_W];
        rd_in_range = (rd_x_i < 5'(MAP_W)) && (rd_y_i < 4'(MAP_H));
        rd_idx      = rd_in_range
                    ? (IDX_W'(rd_y_i) << 4) + (IDX_W'(rd_y_i) << 2) + IDX_W'(rd_x_i)
                    : '0;
        rd_code_o   = rd_in_range ? map_q[{rd_idx, 1'b0} +: CODE_W] : CODE_BORDER;
        level_base  = ROM_AW'(level_sel_i) * ROM_AW'(TILES);
    end

    // Next-state: load sequencing, ROM fill pipeline and write handling
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        fill_vld_d  = 1'b0;
        fill_idx_d  = fill_idx_q;
        map_d       = map_q;
        busy_d      = busy_q;
        load_done_d = 1'b0;
        wr_ack_d    = 1'b0;
        wr_err_d    = wr_err_q;

        // ROM data arrives one cycle after its address, so the fill trails by one tile
        if (fill_vld_q) begin
            map_d[{fill_idx_q, 1'b0} +: CODE_W] = rom_data_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d    = ST_LOAD;
                    rom_addr_d = level_base;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                end else if (wr_req_i && !wr_ack_q) begin
                    wr_ack_d = 1'b1;
                    if (!wr_in_range || (wr_cur == CODE_BORDER)) begin
                        wr_err_d = 1'b1;
                    end else begin
                        wr_err_d = 1'b0;
                        map_d[{wr_idx, 1'b0} +: CODE_W] = wr_code_i;
                    end
                end
            end
            ST_LOAD: begin
                fill_vld_d = 1'b1;
                fill_idx_d = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d      = cnt_q + IDX_W'(1);
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                end
            end
            ST_DRAIN: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                load_done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            fill_vld_q  <= 1'b0;
            fill_idx_q  <= '0;
            map_q       <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            fill_vld_q  <= fill_vld_d;
            fill_idx_q  <= fill_idx_d;
            map_q       <= map_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign busy_o      = busy_q;
    assign load_done_o = load_done_q;
    assign wr_ack_o    = wr_ack_q;
    assign wr_err_o    = wr_err_q;
    assign map_flat_o  = map_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: reset, level load timing, write accept/reject,
// write throughput, load/write collision and reset during a load.
module tb_tile_map_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_start = 1'b0;
    logic [1:0]   level_sel = 2'd0;
    logic [10:0]  rom_addr;
    logic [1:0]   rom_data = 2'd0;
    logic         busy, load_done;
    logic         wr_req = 1'b0;
    logic [4:0]   wr_x = 5'd0;
    logic [3:0]   wr_y = 4'd0;
    logic [1:0]   wr_code = 2'd0;
    logic         wr_ack, wr_err;
    logic [4:0]   rd_x = 5'd0;
    logic [3:0]   rd_y = 4'd0;
    logic [1:0]   rd_code;
    logic [599:0] map_flat;

    int checks = 0;
    int errors = 0;
    int exp_map [0:299];
    bit exp_err_q [$];

    always #5 clk = ~clk;

    // Synchronous level ROM: code = low two address bits
    always @(posedge clk) rom_data <= rom_addr[1:0];

    tile_map_writer dut (
        .clk(clk), .rst_n(rst_n),
        .load_start_i(load_start), .level_sel_i(level_sel),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .busy_o(busy), .load_done_o(load_done),
        .wr_req_i(wr_req), .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_code_i(wr_code),
        .wr_ack_o(wr_ack), .wr_err_o(wr_err),
        .rd_x_i(rd_x), .rd_y_i(rd_y), .rd_code_o(rd_code),
        .map_flat_o(map_flat)
    );

    // First tile where DUT map and model disagree, or -1
    function automatic int map_diff();
        for (int i = 0; i < 300; i++) begin
            if (int'(map_flat[2*i +: 2]) != exp_map[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit model_err(input int x, input int y);
        if (x >= 20 || y >= 15) return 1'b1;
        return exp_map[y*20 + x] == 3;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rd_x = 5'd25; rd_y = 4'd3;
        repeat (2) @(negedge clk);
        checks++;
        if (map_flat !== '0) begin errors++; $display("FAIL reset_map got %h want 0", map_flat); end
        checks++;
        if ({busy, load_done, wr_ack, wr_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {busy, load_done, wr_ack, wr_err});
        end
        checks++;
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++;
        if (rd_code !== 2'd3) begin errors++; $display("FAIL reset_rd_oob got %0d want 3", rd_code); end
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) exp_map[i] = 0;
        @(negedge clk);
    endtask

    task automatic test_load(input int lvl);
        int bad_addr = 0, bad_busy = 0, bad_done = 0, d;
        level_sel = 2'(lvl);
        load_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 302; k++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (k <= 300 && rom_addr !== 11'(lvl*300 + k - 1)) bad_addr++;
            if (busy !== (k <= 301)) bad_busy++;
            if (load_done !== (k == 302)) bad_done++;
        end
        @(negedge clk);
        if (load_done !== 1'b0) bad_done++;
        checks++;
        if (bad_addr != 0) begin errors++; $display("FAIL load_rom_addr got %0d bad cycles want 0", bad_addr); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL load_busy got %0d bad cycles want 0", bad_busy); end
        checks++;
        if (bad_done != 0) begin errors++; $display("FAIL load_done_pulse got %0d bad cycles want 0", bad_done); end
        for (int i = 0; i < 300; i++) exp_map[i] = (lvl*300 + i) & 3;
        d = map_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL load_map tile %0d got %0d want %0d", d, map_flat[2*d +: 2], exp_map[d]); end
        rd_x = 5'd5; rd_y = 4'd2; #1;
        checks++;
        if (rd_code !== 2'(exp_map[45])) begin errors++; $display("FAIL rd_tile45 got %0d want %0d", rd_code, exp_map[45]); end
        rd_x = 5'd19; rd_y = 4'd14; #1;
        checks++;
        if (rd_code !== 2'(exp_map[299])) begin errors++; $display("FAIL rd_tile299 got %0d want %0d", rd_code, exp_map[299]); end
        rd_x = 5'd0; rd_y = 4'd15; #1;
        checks++;
        if (rd_code !== 2'd3) begin errors++; $display("FAIL rd_row_oob got %0d want 3", rd_code); end
    endtask

    task automatic do_write(input int x, input int y, input int code, input string name);
        int lat = -1, d;
        bit e;
        wr_x = 5'(x); wr_y = 4'(y); wr_code = 2'(code);
        wr_req = 1'b1;
        e = model_err(x, y);
        exp_err_q.push_back(e);
        if (!e) exp_map[y*20 + x] = code;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) begin lat = n; break; end
        end
        wr_req = 1'b0;
        checks++;
        if (lat != 0) begin
            errors++; $display("FAIL %s_ack_latency got %0d want 0", name, lat);
            if (lat < 0) void'(exp_err_q.pop_front());
        end
        if (lat >= 0) begin
            e = exp_err_q.pop_front();
            checks++;
            if (wr_err !== e) begin errors++; $display("FAIL %s_err got %b want %b", name, wr_err, e); end
        end
        d = map_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL %s_map tile %0d got %0d want %0d", name, d, map_flat[2*d +: 2], exp_map[d]); end
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0) begin errors++; $display("FAIL %s_ack_width got %b want 0", name, wr_ack); end
    endtask

    task automatic test_write();
        do_write(19, 14, 0, "wr_border");
        do_write(1, 0, 0, "wr_brick");
        do_write(3, 14, 2, "wr_steel");
        do_write(0, 15, 1, "wr_y_oob");
    endtask

    task automatic test_back_to_back();
        int bad_pat = 0, d;
        bit e;
        wr_x = 5'd20; wr_y = 4'd0; wr_code = 2'd1;
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) exp_err_q.push_back(1'b1);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 6) wr_req = 1'b0;
            if (wr_ack !== (n % 2 == 1)) bad_pat++;
            if (wr_ack === 1'b1 && exp_err_q.size() > 0) begin
                e = exp_err_q.pop_front();
                checks++;
                if (wr_err !== e) begin errors++; $display("FAIL b2b_err got %b want %b", wr_err, e); end
            end
        end
        @(negedge clk);
        if (wr_ack !== 1'b0) bad_pat++;
        checks++;
        if (bad_pat != 0) begin errors++; $display("FAIL b2b_ack_spacing got %0d bad cycles want 0", bad_pat); end
        checks++;
        if (exp_err_q.size() != 0) begin
            errors++; $display("FAIL b2b_ack_count got %0d missing want 0", exp_err_q.size());
            exp_err_q.delete();
        end
        d = map_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL b2b_map tile %0d got %0d want %0d", d, map_flat[2*d +: 2], exp_map[d]); end
    endtask

    task automatic test_load_write_collision();
        int early = 0, ack_at = -1, d;
        bit e;
        level_sel = 2'd1;
        load_start = 1'b1;
        wr_x = 5'd2; wr_y = 4'd0; wr_code = 2'd0;
        wr_req = 1'b1;
        for (int i = 0; i < 300; i++) exp_map[i] = (300 + i) & 3;
        e = model_err(2, 0);
        exp_err_q.push_back(e);
        if (!e) exp_map[2] = 0;
        @(posedge clk);
        for (int k = 1; k <= 310; k++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (wr_ack === 1'b1) begin
                if (k <= 302) early++;
                ack_at = k;
                break;
            end
        end
        wr_req = 1'b0;
        checks++;
        if (early != 0) begin errors++; $display("FAIL coll_ack_during_load got %0d want 0", early); end
        checks++;
        if (ack_at != 303) begin errors++; $display("FAIL coll_ack_cycle got %0d want 303", ack_at); end
        if (ack_at >= 0) begin
            e = exp_err_q.pop_front();
            checks++;
            if (wr_err !== e) begin errors++; $display("FAIL coll_err got %b want %b", wr_err, e); end
        end else begin
            exp_err_q.delete();
        end
        d = map_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL coll_map tile %0d got %0d want %0d", d, map_flat[2*d +: 2], exp_map[d]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int done_seen = 0;
        level_sel = 2'd2;
        load_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 150; k++) begin
            @(negedge clk);
            load_start = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 300; i++) exp_map[i] = 0;
        checks++;
        if (map_flat !== '0) begin errors++; $display("FAIL abort_map got nonzero want 0"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (load_done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL abort_load_done got %0d want 0", done_seen); end
        checks++;
        if (busy !== 1'b0 || map_diff() >= 0) begin errors++; $display("FAIL abort_idle got busy=%b diff=%0d want 0/-1", busy, map_diff()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load(1);
        test_write();
        test_back_to_back();
        test_load_write_collision();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
